// File: rtl/iob_split_tracked_if.sv
// Bus bundle for iob_split_tracked: CPU-side IOb request/response plus the fanned-out
// per-target request/response vectors.
interface iob_split_tracked_if #(
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 32
);
    logic                              iob_valid_i;
    logic [ADDR_W-1:0]                 iob_addr_i;
    logic [DATA_W-1:0]                 iob_wdata_i;
    logic [DATA_W/8-1:0]               iob_wstrb_i;
    logic                              iob_ready_o;
    logic                              iob_rvalid_o;
    logic [DATA_W-1:0]                 iob_rdata_o;
    logic [N_OUT-1:0]                  out_valid_o;
    logic [N_OUT*(ADDR_W-SEL_W)-1:0]   out_addr_o;
    logic [N_OUT*DATA_W-1:0]           out_wdata_o;
    logic [N_OUT*DATA_W/8-1:0]         out_wstrb_o;
    logic [N_OUT-1:0]                  out_rvalid_i;
    logic [N_OUT*DATA_W-1:0]           out_rdata_i;
    logic [N_OUT-1:0]                  out_ready_i;
    logic                              err_o;

    // Splitter view.
    modport slave (
        input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
        output iob_ready_o, iob_rvalid_o, iob_rdata_o,
        output out_valid_o, out_addr_o, out_wdata_o, out_wstrb_o,
        input  out_rvalid_i, out_rdata_i, out_ready_i,
        output err_o
    );

    // CPU plus peripheral-array view.
    modport master (
        output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
        input  iob_ready_o, iob_rvalid_o, iob_rdata_o,
        input  out_valid_o, out_addr_o, out_wdata_o, out_wstrb_o,
        output out_rvalid_i, out_rdata_i, out_ready_i,
        input  err_o
    );
endinterface

// File: rtl/iob_split_tracked.sv
// N-way IOb splitter: decodes the address MSBs to a target, tracks outstanding reads so
// responses come back from the owning target, and answers unmapped selects internally.
module iob_split_tracked #(
    parameter int unsigned        N_OUT     = 4,
    parameter int unsigned        SEL_W     = 2,
    parameter int unsigned        ADDR_W    = 28,
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        MAX_PEND  = 4,
    parameter logic [DATA_W-1:0]  ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic           clk_i,
    input  logic           cke_i,
    input  logic           rst_i,
    iob_split_tracked_if.slave bus
);
    localparam int unsigned A_OUT_W = ADDR_W - SEL_W;
    localparam int unsigned CNT_W   = $clog2(MAX_PEND + 1);

    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] pend_sel_q, pend_sel_d;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic             err_rv_q, err_rv_d;
    logic             sel_mapped, pend_mapped, is_read, stall;
    logic             ready, accept, rd_accept, tgt_rvalid, rvalid;

    assign sel         = bus.iob_addr_i[ADDR_W-1 -: SEL_W];
    assign sel_mapped  = 32'(sel) < N_OUT;
    assign pend_mapped = 32'(pend_sel_q) < N_OUT;
    assign is_read     = bus.iob_wstrb_i == '0;

    // Hold off a different target until its predecessor's reads drain, and cap outstanding reads.
    assign stall = bus.iob_valid_i &
                   (((pend_cnt_q != '0) && (sel != pend_sel_q)) ||
                    (is_read && (pend_cnt_q == CNT_W'(MAX_PEND))));

    assign bus.out_addr_o  = {N_OUT{bus.iob_addr_i[A_OUT_W-1:0]}};
    assign bus.out_wdata_o = {N_OUT{bus.iob_wdata_i}};
    assign bus.out_wstrb_o = {N_OUT{bus.iob_wstrb_i}};

    always_comb begin
        bus.out_valid_o = '0;
        ready           = 1'b0;
        if (!stall) begin
            if (sel_mapped) begin
                for (int unsigned k = 0; k < N_OUT; k++) begin
                    if (32'(sel) == k) begin
                        bus.out_valid_o[k] = bus.iob_valid_i;
                        ready              = bus.out_ready_i[k];
                    end
                end
            end else begin
                ready = 1'b1;
            end
        end
    end

    assign bus.iob_ready_o = ready;
    assign accept          = bus.iob_valid_i & ready;
    assign rd_accept       = accept & is_read;
    assign bus.err_o       = accept & ~sel_mapped;

    always_comb begin
        tgt_rvalid      = 1'b0;
        bus.iob_rdata_o = ERR_RDATA;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (32'(pend_sel_q) == k) begin
                tgt_rvalid      = bus.out_rvalid_i[k];
                bus.iob_rdata_o = bus.out_rdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign rvalid           = (pend_cnt_q != '0) & (pend_mapped ? tgt_rvalid : err_rv_q);
    assign bus.iob_rvalid_o = rvalid;

    always_comb begin
        pend_cnt_d = pend_cnt_q;
        pend_sel_d = pend_sel_q;
        err_rv_d   = rd_accept & ~sel_mapped;
        if (rd_accept) begin
            pend_sel_d = sel;
        end
        if (rd_accept && !rvalid) begin
            pend_cnt_d = pend_cnt_q + CNT_W'(1);
        end else if (!rd_accept && rvalid) begin
            pend_cnt_d = pend_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                pend_cnt_q <= '0;
                pend_sel_q <= '0;
                err_rv_q   <= 1'b0;
            end else begin
                pend_cnt_q <= pend_cnt_d;
                pend_sel_q <= pend_sel_d;
                err_rv_q   <= err_rv_d;
            end
        end
    end
endmodule

// File: tb/tb_iob_split_tracked.sv
// Self-checking bench for iob_split_tracked: a default 4-way instance plus a 3-way instance
// for unmapped selects; expected read data is queued on acceptance and popped on rvalid.
module tb_iob_split_tracked;
    logic clk = 1'b0;
    logic cke;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp3_q[$];
    logic [31:0] exp_v;

    always #5 clk = ~clk;

    iob_split_tracked_if #(.N_OUT(4)) bus ();
    iob_split_tracked_if #(.N_OUT(3)) bus3 ();

    iob_split_tracked #(.N_OUT(4)) dut (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .bus(bus.slave)
    );

    iob_split_tracked #(.N_OUT(3)) dut3 (
        .clk_i(clk), .cke_i(cke), .rst_i(rst), .bus(bus3.slave)
    );

    task automatic set_req(input logic v, input logic [27:0] a, input logic [3:0] s,
                           input logic [31:0] d);
        bus.iob_valid_i = v;
        bus.iob_addr_i  = a;
        bus.iob_wstrb_i = s;
        bus.iob_wdata_i = d;
    endtask

    task automatic tgt_resp(input int k, input logic [31:0] d);
        bus.out_rvalid_i    = '0;
        bus.out_rvalid_i[k] = 1'b1;
        bus.out_rdata_i[k*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.iob_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL reset_rvalid: got %b want 0", bus.iob_rvalid_o);
        end
        checks++;
        if (bus.err_o !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b want 0", bus.err_o);
        end
        checks++;
        if (dut.pend_cnt_q !== 3'd0) begin
            errors++; $display("FAIL reset_pend_cnt: got %0d want 0", dut.pend_cnt_q);
        end
        checks++;
        if (bus.out_valid_o !== 4'b0000) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0000", bus.out_valid_o);
        end
    endtask

    task automatic test_basic_read();
        bus.out_ready_i = 4'b0010;
        @(negedge clk);
        set_req(1'b1, 28'h4000010, 4'h0, 32'h0);
        #1;
        checks++;
        if (bus.out_valid_o !== 4'b0010 || bus.iob_ready_o !== 1'b1) begin
            errors++; $display("FAIL basic_fwd: got valid=%b ready=%b want 0010/1",
                               bus.out_valid_o, bus.iob_ready_o);
        end
        checks++;
        if (bus.out_addr_o[26 +: 26] !== 26'h0000010) begin
            errors++; $display("FAIL basic_addr: got %h want 0000010", bus.out_addr_o[26 +: 26]);
        end
        exp_q.push_back(32'h1234);
        @(negedge clk);
        set_req(1'b0, 28'h0, 4'h0, 32'h0);
        #1;
        checks++;
        if (32'(dut.pend_cnt_q) !== exp_q.size() || bus.iob_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL basic_pend1: got cnt=%0d rvalid=%b want %0d/0",
                               dut.pend_cnt_q, bus.iob_rvalid_o, exp_q.size());
        end
        @(negedge clk);
        tgt_resp(1, 32'h1234);
        #1;
        checks++;
        if (bus.iob_rvalid_o !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL basic_rvalid: got %b want 1", bus.iob_rvalid_o);
        end else begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.iob_rdata_o !== exp_v) begin
                errors++; $display("FAIL basic_rdata: got %h want %h", bus.iob_rdata_o, exp_v);
            end
        end
        @(negedge clk);
        bus.out_rvalid_i = '0;
        #1;
        checks++;
        if (32'(dut.pend_cnt_q) !== exp_q.size()) begin
            errors++; $display("FAIL basic_pend0: got %0d want %0d", dut.pend_cnt_q, exp_q.size());
        end
    endtask

    task automatic test_switch_target();
        bus.out_ready_i = 4'b0101;
        @(negedge clk);
        set_req(1'b1, 28'h8000020, 4'h0, 32'h0);
        #1;
        checks++;
        if (bus.iob_ready_o !== 1'b1 || bus.out_valid_o !== 4'b0100) begin
            errors++; $display("FAIL sw_rd2: got ready=%b valid=%b want 1/0100",
                               bus.iob_ready_o, bus.out_valid_o);
        end
        exp_q.push_back(32'hAAAA_0002);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_req(1'b1, 28'h0000040, 4'h0, 32'h0);
            #1;
            checks++;
            if (bus.iob_ready_o !== 1'b0 || bus.out_valid_o !== 4'b0000) begin
                errors++; $display("FAIL sw_stall: got ready=%b valid=%b want 0/0000",
                                   bus.iob_ready_o, bus.out_valid_o);
            end
        end
        @(negedge clk);
        tgt_resp(2, 32'hAAAA_0002);
        #1;
        checks++;
        if (bus.iob_rvalid_o !== 1'b1 || bus.iob_ready_o !== 1'b0 || exp_q.size() == 0) begin
            errors++; $display("FAIL sw_resp: got rvalid=%b ready=%b want 1/0",
                               bus.iob_rvalid_o, bus.iob_ready_o);
        end else begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.iob_rdata_o !== exp_v) begin
                errors++; $display("FAIL sw_rdata: got %h want %h", bus.iob_rdata_o, exp_v);
            end
        end
        @(negedge clk);
        bus.out_rvalid_i = '0;
        #1;
        checks++;
        if (bus.iob_ready_o !== 1'b1 || bus.out_valid_o !== 4'b0001) begin
            errors++; $display("FAIL sw_fwd0: got ready=%b valid=%b want 1/0001",
                               bus.iob_ready_o, bus.out_valid_o);
        end
        exp_q.push_back(32'hBBBB_0000);
        @(negedge clk);
        set_req(1'b0, 28'h0, 4'h0, 32'h0);
        tgt_resp(0, 32'hBBBB_0000);
        #1;
        checks++;
        if (bus.iob_rvalid_o !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL sw_resp0: got rvalid=%b want 1", bus.iob_rvalid_o);
        end else begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.iob_rdata_o !== exp_v) begin
                errors++; $display("FAIL sw_rdata0: got %h want %h", bus.iob_rdata_o, exp_v);
            end
        end
        @(negedge clk);
        bus.out_rvalid_i = '0;
    endtask

    task automatic test_max_pend();
        bus.out_ready_i = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_req(1'b1, 28'hC000000 | 28'(i * 4), 4'h0, 32'h0);
            #1;
            checks++;
            if (bus.iob_ready_o !== 1'b1 || bus.out_valid_o !== 4'b1000) begin
                errors++; $display("FAIL mp_fill%0d: got ready=%b valid=%b want 1/1000",
                                   i, bus.iob_ready_o, bus.out_valid_o);
            end
            exp_q.push_back(32'h3000_0000 + 32'(i));
        end
        @(negedge clk);
        set_req(1'b1, 28'hC000100, 4'h0, 32'h0);
        #1;
        checks++;
        if (32'(dut.pend_cnt_q) !== 4 || bus.iob_ready_o !== 1'b0 ||
            bus.out_valid_o !== 4'b0000) begin
            errors++; $display("FAIL mp_full: got cnt=%0d ready=%b valid=%b want 4/0/0000",
                               dut.pend_cnt_q, bus.iob_ready_o, bus.out_valid_o);
        end
        @(negedge clk);
        set_req(1'b1, 28'hC000200, 4'hF, 32'h5555_5555);
        #1;
        checks++;
        if (bus.iob_ready_o !== 1'b1 || bus.out_valid_o !== 4'b1000 ||
            bus.out_wdata_o[96 +: 32] !== 32'h5555_5555) begin
            errors++; $display("FAIL mp_write: got ready=%b valid=%b wdata=%h want 1/1000/55555555",
                               bus.iob_ready_o, bus.out_valid_o, bus.out_wdata_o[96 +: 32]);
        end
        // Response frees a slot, but the read presented alongside still stalls this cycle.
        @(negedge clk);
        set_req(1'b1, 28'hC000300, 4'h0, 32'h0);
        tgt_resp(3, exp_q[0]);
        #1;
        checks++;
        if (bus.iob_ready_o !== 1'b0 || bus.iob_rvalid_o !== 1'b1) begin
            errors++; $display("FAIL mp_free: got ready=%b rvalid=%b want 0/1",
                               bus.iob_ready_o, bus.iob_rvalid_o);
        end else begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.iob_rdata_o !== exp_v) begin
                errors++; $display("FAIL mp_free_rdata: got %h want %h", bus.iob_rdata_o, exp_v);
            end
        end
        @(negedge clk);
        tgt_resp(3, exp_q[0]);
        #1;
        checks++;
        if (bus.iob_ready_o !== 1'b1 || bus.iob_rvalid_o !== 1'b1) begin
            errors++; $display("FAIL mp_both: got ready=%b rvalid=%b want 1/1",
                               bus.iob_ready_o, bus.iob_rvalid_o);
        end else begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.iob_rdata_o !== exp_v) begin
                errors++; $display("FAIL mp_both_rdata: got %h want %h", bus.iob_rdata_o, exp_v);
            end
        end
        exp_q.push_back(32'h3000_0010);
        @(negedge clk);
        bus.out_rvalid_i = '0;
        #1;
        checks++;
        if (32'(dut.pend_cnt_q) !== exp_q.size() || bus.iob_ready_o !== 1'b1) begin
            errors++; $display("FAIL mp_hold: got cnt=%0d ready=%b want %0d/1",
                               dut.pend_cnt_q, bus.iob_ready_o, exp_q.size());
        end
        exp_q.push_back(32'h3000_0011);
        @(negedge clk);
        #1;
        checks++;
        if (32'(dut.pend_cnt_q) !== 4 || bus.iob_ready_o !== 1'b0) begin
            errors++; $display("FAIL mp_refull: got cnt=%0d ready=%b want 4/0",
                               dut.pend_cnt_q, bus.iob_ready_o);
        end
        set_req(1'b0, 28'h0, 4'h0, 32'h0);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            tgt_resp(3, exp_q[0]);
            #1;
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.iob_rvalid_o !== 1'b1 || bus.iob_rdata_o !== exp_v) begin
                errors++; $display("FAIL mp_drain: got rvalid=%b rdata=%h want 1/%h",
                                   bus.iob_rvalid_o, bus.iob_rdata_o, exp_v);
            end
        end
        @(negedge clk);
        bus.out_rvalid_i = '0;
        #1;
        checks++;
        if (dut.pend_cnt_q !== 3'd0) begin
            errors++; $display("FAIL mp_empty: got %0d want 0", dut.pend_cnt_q);
        end
    endtask

    task automatic test_unmapped();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus3.iob_valid_i = 1'b1;
            bus3.iob_addr_i  = 28'hC000008 + 28'(i * 4);
            bus3.iob_wstrb_i = 4'h0;
            #1;
            checks++;
            if (bus3.iob_ready_o !== 1'b1 || bus3.err_o !== 1'b1 || bus3.out_valid_o !== 3'b000) begin
                errors++; $display("FAIL um_acc%0d: got ready=%b err=%b valid=%b want 1/1/000",
                                   i, bus3.iob_ready_o, bus3.err_o, bus3.out_valid_o);
            end
            if (i == 1) begin
                checks++;
                if (bus3.iob_rvalid_o !== 1'b1 || exp3_q.size() == 0) begin
                    errors++; $display("FAIL um_b2b_rvalid: got %b want 1", bus3.iob_rvalid_o);
                end else begin
                    exp_v = exp3_q.pop_front();
                    checks++;
                    if (bus3.iob_rdata_o !== exp_v) begin
                        errors++; $display("FAIL um_rdata0: got %h want %h", bus3.iob_rdata_o, exp_v);
                    end
                end
            end
            exp3_q.push_back(32'hDEAD_BEEF);
        end
        @(negedge clk);
        bus3.iob_valid_i = 1'b1;
        bus3.iob_wstrb_i = 4'hF;
        #1;
        checks++;
        if (bus3.iob_rvalid_o !== 1'b1 || bus3.err_o !== 1'b1 || exp3_q.size() == 0) begin
            errors++; $display("FAIL um_rvalid1: got rvalid=%b err=%b want 1/1",
                               bus3.iob_rvalid_o, bus3.err_o);
        end else begin
            exp_v = exp3_q.pop_front();
            checks++;
            if (bus3.iob_rdata_o !== exp_v) begin
                errors++; $display("FAIL um_rdata1: got %h want %h", bus3.iob_rdata_o, exp_v);
            end
        end
        @(negedge clk);
        bus3.iob_valid_i = 1'b0;
        #1;
        checks++;
        if (bus3.iob_rvalid_o !== 1'b0 || bus3.err_o !== 1'b0 || dut3.pend_cnt_q !== 3'd0) begin
            errors++; $display("FAIL um_idle: got rvalid=%b err=%b cnt=%0d want 0/0/0",
                               bus3.iob_rvalid_o, bus3.err_o, dut3.pend_cnt_q);
        end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        tgt_resp(0, 32'h0BAD_0000);
        #1;
        checks++;
        if (bus.iob_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL sp_idle: got %b want 0", bus.iob_rvalid_o);
        end
        bus.out_ready_i = 4'b0010;
        @(negedge clk);
        bus.out_rvalid_i = '0;
        set_req(1'b1, 28'h4000000, 4'h0, 32'h0);
        #1;
        exp_q.push_back(32'h1111_0001);
        @(negedge clk);
        set_req(1'b0, 28'h0, 4'h0, 32'h0);
        tgt_resp(2, 32'h0BAD_0002);
        #1;
        checks++;
        if (bus.iob_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL sp_other: got %b want 0", bus.iob_rvalid_o);
        end
        @(negedge clk);
        tgt_resp(1, 32'h1111_0001);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (32'(dut.pend_cnt_q) !== 1 || bus.iob_rvalid_o !== 1'b1 || bus.iob_rdata_o !== exp_v) begin
            errors++; $display("FAIL sp_resp: got cnt=%0d rvalid=%b rdata=%h want 1/1/%h",
                               dut.pend_cnt_q, bus.iob_rvalid_o, bus.iob_rdata_o, exp_v);
        end
        @(negedge clk);
        bus.out_rvalid_i = '0;
    endtask

    task automatic test_reset_pending();
        bus.out_ready_i = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            set_req(1'b1, 28'h4000000 + 28'(i * 4), 4'h0, 32'h0);
            #1;
            exp_q.push_back(32'h2222_0000 + 32'(i));
        end
        @(negedge clk);
        set_req(1'b0, 28'h0, 4'h0, 32'h0);
        #1;
        checks++;
        if (32'(dut.pend_cnt_q) !== exp_q.size()) begin
            errors++; $display("FAIL rp_pend2: got %0d want %0d", dut.pend_cnt_q, exp_q.size());
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        tgt_resp(1, 32'h2222_0000);
        #1;
        checks++;
        if (dut.pend_cnt_q !== 3'd0 || bus.iob_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL rp_late: got cnt=%0d rvalid=%b want 0/0",
                               dut.pend_cnt_q, bus.iob_rvalid_o);
        end
        @(negedge clk);
        bus.out_rvalid_i = '0;
        #1;
        checks++;
        if (dut.pend_cnt_q !== 3'd0) begin
            errors++; $display("FAIL rp_after: got %0d want 0", dut.pend_cnt_q);
        end
    endtask

    task automatic test_cke();
        bus.out_ready_i = 4'b0101;
        @(negedge clk);
        set_req(1'b1, 28'h8000000, 4'h0, 32'h0);
        #1;
        exp_q.push_back(32'h4444_0002);
        @(negedge clk);
        cke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_req(1'b1, 28'h0000000, 4'h0, 32'h0);
            #1;
            checks++;
            if (32'(dut.pend_cnt_q) !== 1 || dut.pend_sel_q !== 2'd2 || bus.iob_ready_o !== 1'b0) begin
                errors++; $display("FAIL cke_frozen%0d: got cnt=%0d sel=%0d ready=%b want 1/2/0",
                                   i, dut.pend_cnt_q, dut.pend_sel_q, bus.iob_ready_o);
            end
            @(negedge clk);
        end
        cke = 1'b1;
        set_req(1'b0, 28'h0, 4'h0, 32'h0);
        tgt_resp(2, 32'h4444_0002);
        #1;
        checks++;
        if (bus.iob_rvalid_o !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL cke_resp: got %b want 1", bus.iob_rvalid_o);
        end else begin
            exp_v = exp_q.pop_front();
            checks++;
            if (bus.iob_rdata_o !== exp_v) begin
                errors++; $display("FAIL cke_rdata: got %h want %h", bus.iob_rdata_o, exp_v);
            end
        end
        @(negedge clk);
        bus.out_rvalid_i = '0;
        set_req(1'b1, 28'h0000000, 4'h0, 32'h0);
        #1;
        checks++;
        if (bus.iob_ready_o !== 1'b1 || bus.out_valid_o !== 4'b0001) begin
            errors++; $display("FAIL cke_resume: got ready=%b valid=%b want 1/0001",
                               bus.iob_ready_o, bus.out_valid_o);
        end
        exp_q.push_back(32'h4444_0000);
        @(negedge clk);
        set_req(1'b0, 28'h0, 4'h0, 32'h0);
        tgt_resp(0, 32'h4444_0000);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if (bus.iob_rvalid_o !== 1'b1 || bus.iob_rdata_o !== exp_v) begin
            errors++; $display("FAIL cke_resp0: got rvalid=%b rdata=%h want 1/%h",
                               bus.iob_rvalid_o, bus.iob_rdata_o, exp_v);
        end
        @(negedge clk);
        bus.out_rvalid_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cke = 1'b1;
        rst = 1'b1;
        set_req(1'b0, 28'h0, 4'h0, 32'h0);
        bus.out_rvalid_i = '0;
        bus.out_ready_i  = '0;
        for (int k = 0; k < 4; k++) bus.out_rdata_i[k*32 +: 32] = 32'hF000_0000 + 32'(k);
        bus3.iob_valid_i  = 1'b0;
        bus3.iob_addr_i   = '0;
        bus3.iob_wdata_i  = '0;
        bus3.iob_wstrb_i  = '0;
        bus3.out_rvalid_i = '0;
        bus3.out_ready_i  = 3'b111;
        bus3.out_rdata_i  = {32'hE000_0002, 32'hE000_0001, 32'hE000_0000};

        test_reset();
        test_basic_read();
        test_switch_target();
        test_max_pend();
        test_unmapped();
        test_spurious();
        test_reset_pending();
        test_cke();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
